// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and data-memory wait freezes.
// Optional HAZARD_PERF_EN macro adds the saturating stall_cnt performance counter port.
module hazard_control_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] IFID_rs1,
    input  logic [4:0] IFID_rs2,
    input  logic [4:0] IDEX_rd,
    input  logic       IDEX_MemRead,
    input  logic       EX_branch_taken,
    input  logic       mem_req,
    input  logic       mem_ack,
    output logic       PC_Write,
    output logic       IFID_Write,
    output logic       IDEX_Bubble,
    output logic       IFID_Flush,
    output logic       IDEX_Flush,
    output logic       Pipe_Freeze,
    output logic       mem_err
`ifdef HAZARD_PERF_EN
    , output logic [15:0] stall_cnt
`endif
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       load_use, freeze, timeout_hit;

    assign load_use    = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                         ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));
    assign freeze      = mem_req && !mem_ack;
    // An ack in the last allowed cycle wins over the timeout.
    assign timeout_hit = (state == MEM_WAIT) && !mem_ack && (wait_cnt == TIMEOUT_M1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            // Held at zero in RUN, so every entry into MEM_WAIT starts from zero.
            wait_cnt <= (state == RUN) ? 8'd0 : wait_cnt + 8'd1;
            if (timeout_hit)
                mem_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        Pipe_Freeze = 1'b0;
        if (!rst_n) begin
            IDEX_Bubble = 1'b1;
            state_nxt   = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        Pipe_Freeze = 1'b1;
                        state_nxt   = MEM_WAIT;
                    end else if (EX_branch_taken) begin
                        PC_Write   = 1'b1;
                        IFID_Write = 1'b1;
                        IFID_Flush = 1'b1;
                        IDEX_Flush = 1'b1;
                    end else if (load_use) begin
                        IDEX_Bubble = 1'b1;
                    end else begin
                        PC_Write   = 1'b1;
                        IFID_Write = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // Branch input is ignored here; EX is frozen so it is seen again in RUN.
                    if (mem_ack) begin
                        state_nxt = RUN;
                    end else begin
                        Pipe_Freeze = 1'b1;
                        if (timeout_hit)
                            state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= 16'd0;
        else if (!PC_Write && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: driver queues hand-computed outputs,
// a negedge monitor pops and compares them (plus stall_cnt when HAZARD_PERF_EN is defined).
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] IFID_rs1, IFID_rs2, IDEX_rd;
    logic       IDEX_MemRead, EX_branch_taken, mem_req, mem_ack;
    logic       PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Pipe_Freeze, mem_err;
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt;
`endif

    hazard_control_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2), .IDEX_rd(IDEX_rd),
        .IDEX_MemRead(IDEX_MemRead), .EX_branch_taken(EX_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble),
        .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .Pipe_Freeze(Pipe_Freeze),
        .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Output vector: {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Pipe_Freeze, mem_err}
    localparam logic [6:0] N   = 7'b1100000;
    localparam logic [6:0] RST = 7'b0010000;
    localparam logic [6:0] LU  = 7'b0010000;
    localparam logic [6:0] BR  = 7'b1101100;
    localparam logic [6:0] FRZ = 7'b0000010;
    localparam logic [6:0] ACK = 7'b0000000;

    typedef struct {
        string      name;
        logic       rst;
        logic [6:0] o;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   mcnt  = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [6:0] act;
            e   = q.pop_front();
            act = {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Pipe_Freeze, mem_err};
            n_vec++;
            if (act !== e.o) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", e.name, act, e.o);
            end
`ifdef HAZARD_PERF_EN
            n_vec++;
            if (stall_cnt !== 16'(mcnt)) begin
                n_bad++;
                $display("FAIL stall_cnt@%s: got %0d want %0d", e.name, stall_cnt, mcnt);
            end
`endif
            if (!e.rst)
                mcnt = 0;
            else if (!e.o[6] && mcnt < 65535)
                mcnt++;
        end
    end

    task automatic vec(input string nm, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr, input logic br,
                       input logic req, input logic ack, input logic rst, input logic [6:0] o);
        exp_t e;
        @(posedge clk);
        #1;
        IFID_rs1 = rs1; IFID_rs2 = rs2; IDEX_rd = rd; IDEX_MemRead = mr;
        EX_branch_taken = br; mem_req = req; mem_ack = ack; rst_n = rst;
        e.name = nm; e.rst = rst; e.o = o;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; IFID_rs1 = '0; IFID_rs2 = '0; IDEX_rd = '0;
        IDEX_MemRead = 1'b0; EX_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;

        vec("rst0",         0, 0, 0, 0, 0, 0, 0, 0, RST);
        vec("rst_req",      0, 0, 0, 0, 0, 1, 0, 0, RST);
        vec("normal",       1, 2, 3, 0, 0, 0, 0, 1, N);
        vec("ld_x0",        0, 0, 0, 1, 0, 0, 0, 1, N);
        vec("ld_use_rs2",   1, 5, 5, 1, 0, 0, 0, 1, LU);
        vec("after_bubble", 1, 5, 5, 0, 0, 0, 0, 1, N);
        vec("ld_use_rs1",   7, 4, 7, 1, 0, 0, 0, 1, LU);
        vec("ld_nomatch",   3, 4, 7, 1, 0, 0, 0, 1, N);
        vec("rd_no_load",   7, 7, 7, 0, 0, 0, 0, 1, N);
        vec("br_ld_use",    5, 0, 5, 1, 1, 0, 0, 1, BR);
        vec("br",           0, 0, 0, 0, 1, 0, 0, 1, BR);
        vec("req_ack_run",  0, 0, 0, 0, 0, 1, 1, 1, N);
        // 3-cycle memory wait with branch and load-use pending
        vec("frz_run",      5, 0, 5, 1, 1, 1, 0, 1, FRZ);
        vec("wait1",        5, 0, 5, 1, 1, 1, 0, 1, FRZ);
        vec("wait2",        5, 0, 5, 1, 1, 1, 0, 1, FRZ);
        vec("wait_ack",     5, 0, 5, 1, 1, 1, 1, 1, ACK);
        vec("post_wait_br", 5, 0, 5, 1, 1, 0, 0, 1, BR);
        vec("normal2",      0, 0, 0, 0, 0, 0, 0, 1, N);
        // ack on the last allowed wait cycle beats the timeout
        vec("tie_frz",      0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("tie_w0",       0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("tie_w1",       0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("tie_w2",       0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("tie_ack",      0, 0, 0, 0, 0, 1, 1, 1, ACK);
        vec("tie_noerr",    0, 0, 0, 0, 0, 0, 0, 1, N);
        // reset in the would-be timeout cycle aborts the wait without an error
        vec("abort_frz",    0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("abort_w0",     0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("abort_w1",     0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("abort_w2",     0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("abort_rst",    0, 0, 0, 0, 0, 1, 0, 0, RST);
        vec("abort_run",    0, 0, 0, 0, 0, 0, 0, 1, N);
        // load-use stall plus 3-cycle wait: five PC_Write=0 cycles
        vec("perf_lu",      0, 9, 9, 1, 0, 0, 0, 1, LU);
        vec("perf_bub",     0, 9, 9, 0, 0, 0, 0, 1, N);
        vec("perf_frz",     0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("perf_w1",      0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("perf_w2",      0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("perf_ack",     0, 0, 0, 0, 0, 1, 1, 1, ACK);
        vec("perf_run",     0, 0, 0, 0, 0, 0, 0, 1, N);
        // timeout after four MEM_WAIT cycles, sticky until reset
        vec("to_frz",       0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("to_w0",        0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("to_w1",        0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("to_w2",        0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("to_w3",        0, 0, 0, 0, 0, 1, 0, 1, FRZ);
        vec("err_refrz",    0, 0, 0, 0, 0, 1, 0, 1, 7'b0000011);
        vec("err_wait",     0, 0, 0, 0, 0, 0, 0, 1, 7'b0000011);
        vec("err_ack",      0, 0, 0, 0, 0, 0, 1, 1, 7'b0000001);
        vec("err_sticky",   0, 0, 0, 0, 0, 0, 0, 1, 7'b1100001);
        vec("err_rst",      0, 0, 0, 0, 0, 0, 0, 0, 7'b0010001);
        vec("err_clr",      0, 0, 0, 0, 0, 0, 0, 1, N);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
